muldiv_sequencer: RTL and testbench

// - Multi-cycle RV32M multiply/divide sequencer for the Execute stage, beside the single-cycle ALU.
// - Accepts one M-extension op and iterates a shared shift/add-subtract datapath for XLEN steps.
// - Stalls the pipeline via stallReq until the result is ready.
// - Handles RISC-V divide-by-zero and signed-overflow corner cases without iterating.

---
 rtl/muldiv_sequencer.sv | 138 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer : iterative RV32M multiply/divide unit, one radix-2 step/clk
// Revision 1.0
// ============================================================================
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int            c_cw   = $clog2(XLEN) + 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(XLEN - 1);
  localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  logic [2:0]          r_op;
  logic                r_sign_a, r_sign_b;
  logic [XLEN-1:0]     r_divisor;
  logic [2*XLEN-1:0]   r_acc;
  logic [c_cw-1:0]     r_cnt;
  logic                r_busy, r_done;
  logic [XLEN-1:0]     r_result;

  // Operand decode at accept time
  logic            w_a_signed, w_b_signed, w_sa, w_sb;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_b_zero, w_ovf, w_special, w_accept;
  logic [XLEN-1:0] w_special_res;

  assign w_a_signed = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_sa      = w_a_signed & operand_a[XLEN-1];
  assign w_sb      = w_b_signed & operand_b[XLEN-1];
  assign w_mag_a   = w_sa ? -operand_a : operand_a;
  assign w_mag_b   = w_sb ? -operand_b : operand_b;
  assign w_b_zero  = funct3[2] && (operand_b == '0);
  assign w_ovf     = funct3[2] && !funct3[0] && (operand_a == c_min) && (operand_b == '1);
  assign w_special = w_b_zero || w_ovf;
  assign w_accept  = (r_state == S_IDLE) && start && !flush;
  assign w_special_res = w_b_zero ? (funct3[1] ? operand_a : '1)
                                  : (funct3[1] ? '0 : c_min);

  // Shared datapath: shift-add multiply / restoring divide on one accumulator
  logic [XLEN:0]     w_mul_sum, w_rem_sh, w_diff;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_acc_next, w_prod_fix;
  logic [XLEN-1:0]   w_quot, w_rem, w_final;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_divisor} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff     = w_rem_sh - {1'b0, r_divisor};
  assign w_div_next = w_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;
  assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_acc_next : w_acc_next;
  assign w_quot     = w_acc_next[XLEN-1:0];
  assign w_rem      = w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_final = '0;
    case (r_op)
      3'b000:                 w_final = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = (r_sign_a ^ r_sign_b) ? -w_quot : w_quot;
      default:                w_final = r_sign_a ? -w_rem : w_rem;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = w_special ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (flush)                w_state_next = S_IDLE;
        else if (r_cnt == c_last) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_divisor <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_BUSY);
      r_done  <= (w_state_next == S_DONE);
      if (w_accept) begin
        r_op      <= funct3;
        r_sign_a  <= w_sa;
        r_sign_b  <= w_sb;
        r_divisor <= w_mag_b;
        r_acc     <= {{XLEN{1'b0}}, w_mag_a};
        r_cnt     <= '0;
        if (w_special) r_result <= w_special_res;
      end else if (r_state == S_BUSY && !flush) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == c_last) r_result <= w_final;
      end
    end
  end

  assign stall_req = w_accept || (r_state == S_BUSY);
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_muldiv_sequencer : scoreboard bench with arithmetic reference model
// Revision 1.0
// ============================================================================
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        stall_req, busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_result = '0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .stall_req(stall_req), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("result", result, sb_q.pop_front());
    end
  end

  // Issue one op and check latency / stall length; hold_start keeps start high while busy
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit hold_start);
    int cyc, stalls, exp_lat;
    bit special;
    special = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_lat = special ? 1 : 33;
    @(negedge clk);
    start = 1'b1; funct3 = f; operand_a = a; operand_b = b;
    sb_q.push_back(ref_model(f, a, b));
    last_result = ref_model(f, a, b);
    #1;
    cyc = 0; stalls = 0;
    while (!done && cyc < 100) begin
      if (stall_req) stalls++;
      @(negedge clk);
      operand_a = $urandom; operand_b = $urandom; funct3 = 3'($urandom);
      start = hold_start;
      #1;
      if (done) start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'(exp_lat));
    check("stall_cycles", 32'(stalls), 32'(exp_lat));
    @(posedge clk);
  endtask

  initial begin
    #3;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    issue(3'd0, 32'd7,         32'hFFFF_FFFD, 1'b0);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(3'd4, 32'hFFFF_FFEC, 32'd3,         1'b1);
    issue(3'd6, 32'hFFFF_FFEC, 32'd3,         1'b0);
    issue(3'd5, 32'd100,       32'd7,         1'b0);
    issue(3'd7, 32'd100,       32'd7,         1'b0);
    issue(3'd4, 32'h1234_5678, 32'd0,         1'b0);
    issue(3'd6, 32'd5,         32'd0,         1'b0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Flush a divide at step 10: no done pulse, result untouched
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; operand_a = 32'd1000; operand_b = 32'd9;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_stall", {31'b0, stall_req}, 32'd0);
    check("flush_result", result, last_result);
    repeat (40) @(negedge clk);
    check("flush_result_late", result, last_result);
    issue(3'd5, 32'd1000, 32'd9, 1'b0);

    // start together with flush in IDLE accepts nothing
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; operand_a = 32'd3; operand_b = 32'd4;
    #1;
    check("startflush_stall", {31'b0, stall_req}, 32'd0);
    @(negedge clk); start = 1'b0; flush = 1'b0;
    #1;
    check("startflush_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 40; i++)
      issue(3'($urandom), rnd_op(), rnd_op(), 1'($urandom));

    // Asynchronous reset in the middle of an op
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; operand_a = 32'd6; operand_b = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_no_done", result, 32'd0);
    issue(3'd7, 32'd77, 32'd10, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
